mssd_frame_tx: RTL

Upstream framer for the MSSD serial link. Accepts one parallel request per valid/ready handshake and serialises it onto a single line as start bit, destination field, length field, payload and stop bit, then enforces an idle gap. Its ser_out drives the serial input of the MSSD receiver/demux controller.

---
 rtl/mssd_pkg.sv | 20 ++
 rtl/mssd_piso.sv | 27 ++
 rtl/mssd_frame_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mssd_pkg.sv
// Shared field widths and framer state encoding for the MSSD serial link.
// The MSSD receiver imports the same field widths.
package mssd_pkg;

    localparam int unsigned DEST_W = 2;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned MAXLEN = (1 << LEN_W) - 1;
    localparam int unsigned FCNT_W = (DEST_W > LEN_W) ? DEST_W : LEN_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DEST,
        S_LEN,
        S_DATA,
        S_STOP,
        S_GAP
    } frame_state_e;

endpackage

// File: rtl/mssd_piso.sv
// Loadable parallel-in/serial-out shift register; the MSB is the serial tap.
module mssd_piso #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/mssd_frame_tx.sv
// MSSD upstream framer: serialises start, dest, len, payload and stop bits,
// then holds the line high for GAP cycles before accepting the next request.
module mssd_frame_tx
    import mssd_pkg::*;
#(
    parameter int unsigned GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [MAXLEN-1:0] in_data,
    input  logic              in_bad_stop,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done,
    output logic              reject
);

    localparam int unsigned       GAP_CW    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_CW-1:0] GAP_LOAD  = GAP_CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [FCNT_W-1:0] DEST_LOAD = FCNT_W'(DEST_W - 1);
    localparam logic [FCNT_W-1:0] LEN_LOAD  = FCNT_W'(LEN_W - 1);

    frame_state_e      state, state_next;
    logic [FCNT_W-1:0] fcnt, fcnt_next;
    logic [LEN_W-1:0]  dcnt, dcnt_next;
    logic [GAP_CW-1:0] gcnt, gcnt_next;
    logic              bad_stop_q;
    logic              accept, accept_frame;
    logic              dest_msb, len_msb, data_msb;
    logic              ser_next;
    logic [MAXLEN-1:0] data_aligned;

    assign accept       = in_valid && in_ready;
    assign accept_frame = accept && (in_len != '0);
    assign data_aligned = in_data << (LEN_W'(MAXLEN) - in_len);

    // Each shifter advances on the edge that puts its current MSB on the line.
    mssd_piso #(.W(DEST_W)) u_dest_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept_frame),
        .shift (state_next == S_DEST),
        .d     (in_dest),
        .msb   (dest_msb)
    );

    mssd_piso #(.W(LEN_W)) u_len_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept_frame),
        .shift (state_next == S_LEN),
        .d     (in_len),
        .msb   (len_msb)
    );

    mssd_piso #(.W(MAXLEN)) u_data_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept_frame),
        .shift (state_next == S_DATA),
        .d     (data_aligned),
        .msb   (data_msb)
    );

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        dcnt_next  = dcnt;
        gcnt_next  = gcnt;
        case (state)
            S_IDLE: begin
                if (accept_frame) begin
                    state_next = S_START;
                    dcnt_next  = in_len - 1'b1;
                end
            end
            S_START: begin
                state_next = S_DEST;
                fcnt_next  = DEST_LOAD;
            end
            S_DEST: begin
                if (fcnt == '0) begin
                    state_next = S_LEN;
                    fcnt_next  = LEN_LOAD;
                end else begin
                    fcnt_next = fcnt - 1'b1;
                end
            end
            S_LEN: begin
                if (fcnt == '0) begin
                    state_next = S_DATA;
                end else begin
                    fcnt_next = fcnt - 1'b1;
                end
            end
            S_DATA: begin
                if (dcnt == '0) begin
                    state_next = S_STOP;
                end else begin
                    dcnt_next = dcnt - 1'b1;
                end
            end
            S_STOP: begin
                if (GAP == 0) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_GAP;
                    gcnt_next  = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (gcnt == '0) begin
                    state_next = S_IDLE;
                end else begin
                    gcnt_next = gcnt - 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        ser_next = 1'b1;
        case (state_next)
            S_START: ser_next = 1'b0;
            S_DEST:  ser_next = dest_msb;
            S_LEN:   ser_next = len_msb;
            S_DATA:  ser_next = data_msb;
            S_STOP:  ser_next = ~bad_stop_q;
            default: ser_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            fcnt       <= '0;
            dcnt       <= '0;
            gcnt       <= '0;
            bad_stop_q <= 1'b0;
            ser_out    <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            reject     <= 1'b0;
        end else begin
            state      <= state_next;
            fcnt       <= fcnt_next;
            dcnt       <= dcnt_next;
            gcnt       <= gcnt_next;
            if (accept_frame) begin
                bad_stop_q <= in_bad_stop;
            end
            ser_out    <= ser_next;
            in_ready   <= (state_next == S_IDLE);
            busy       <= (state_next != S_IDLE);
            frame_done <= (state_next == S_STOP);
            reject     <= accept && (in_len == '0);
        end
    end

endmodule
